// File: rtl/fft_frame_ctrl_if.sv
// Stream channels between the FFT frame sequencer and its neighbours:
// config word to the core, upstream samples, core data in/out and downstream ready.
interface fft_frame_ctrl_if;
    logic [23:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;

    logic [31:0] src_tdata;
    logic        src_tvalid;
    logic        src_tready;

    logic [31:0] fft_in_tdata;
    logic        fft_in_tvalid;
    logic        fft_in_tlast;
    logic        fft_in_tready;

    logic        fft_out_tvalid;
    logic        fft_out_tlast;
    logic        fft_out_tready;

    logic        snk_tready;

    // Sequencer side
    modport master (
        output cfg_tdata, cfg_tvalid,
        input  cfg_tready,
        input  src_tdata, src_tvalid,
        output src_tready,
        output fft_in_tdata, fft_in_tvalid, fft_in_tlast,
        input  fft_in_tready,
        input  fft_out_tvalid, fft_out_tlast,
        output fft_out_tready,
        input  snk_tready
    );

    // Core / source / sink side
    modport slave (
        input  cfg_tdata, cfg_tvalid,
        output cfg_tready,
        output src_tdata, src_tvalid,
        input  src_tready,
        input  fft_in_tdata, fft_in_tvalid, fft_in_tlast,
        output fft_in_tready,
        output fft_out_tvalid, fft_out_tlast,
        input  fft_out_tready,
        output snk_tready
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// FFT frame sequencer: issues one config word, gates one N-sample frame into the core,
// counts N results back out, and reports done, frame count and a sticky error.
module fft_frame_ctrl #(
    parameter int unsigned LOG2_N    = 3,
    parameter logic [14:0] SCALE_SCH = 15'h0220
) (
    input  logic                    aclk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    fwd,
    input  logic                    clr_err,
    fft_frame_ctrl_if.master        bus,
    input  logic                    ev_tlast_missing,
    input  logic                    ev_tlast_unexpected,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             frame_cnt
);

    if (LOG2_N < 3 || LOG2_N > 16) begin : g_bad_log2_n
        $error("fft_frame_ctrl: LOG2_N must be in 3..16");
    end

    typedef enum logic [1:0] {StIdle, StCfg, StLoad, StUnload} state_e;

    localparam logic [LOG2_N-1:0] LastBeat   = '1;
    localparam logic [4:0]        Log2NField = 5'(LOG2_N);

    state_e              state_q, state_d;
    logic [23:0]         cfg_tdata_q, cfg_tdata_d;
    logic [LOG2_N-1:0]   in_cnt_q, in_cnt_d;
    logic [LOG2_N-1:0]   out_cnt_q, out_cnt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic in_load, out_open;
    logic in_hs, out_hs, out_last, core_event;
    logic err_set, abort;

    assign in_load  = (state_q == StLoad);
    assign out_open = (state_q == StLoad) || (state_q == StUnload);

    // In-path is a pure combinational gate; nothing is buffered here.
    always_comb begin
        bus.cfg_tvalid     = (state_q == StCfg);
        bus.cfg_tdata      = cfg_tdata_q;
        bus.src_tready     = in_load & bus.fft_in_tready;
        bus.fft_in_tvalid  = in_load & bus.src_tvalid;
        bus.fft_in_tdata   = in_load ? bus.src_tdata : '0;
        bus.fft_in_tlast   = in_load & (in_cnt_q == LastBeat);
        bus.fft_out_tready = out_open & bus.snk_tready;
    end

    assign in_hs      = bus.fft_in_tvalid & bus.fft_in_tready;
    assign out_hs     = bus.fft_out_tvalid & bus.fft_out_tready;
    assign out_last   = (out_cnt_q == LastBeat);
    assign core_event = ev_tlast_missing | ev_tlast_unexpected;

    always_comb begin
        state_d     = state_q;
        cfg_tdata_d = cfg_tdata_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_set     = 1'b0;
        abort       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !err_q && !clr_err) begin
                    state_d     = StCfg;
                    cfg_tdata_d = {SCALE_SCH, fwd, 3'b000, Log2NField};
                end
            end
            StCfg: begin
                if (bus.cfg_tvalid && bus.cfg_tready) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == LastBeat) begin
                        state_d = StUnload;
                    end
                end
            end
            StUnload: begin
            end
            default: state_d = StIdle;
        endcase

        // Result counting runs in both LOAD and UNLOAD; the counter wraps to 0 on the last beat.
        if (out_hs) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (state_q == StUnload && out_last) begin
                state_d     = StIdle;
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                err_set     = !bus.fft_out_tlast;
            end else if (bus.fft_out_tlast && !out_last) begin
                err_set = 1'b1;
                abort   = 1'b1;
            end
        end

        // A core event overrides a frame end arriving in the same cycle.
        if (state_q != StIdle && core_event) begin
            err_set     = 1'b1;
            abort       = 1'b1;
            done_d      = 1'b0;
            frame_cnt_d = frame_cnt_q;
        end

        if (abort) begin
            state_d   = StIdle;
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cfg_tdata_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_tdata_q <= cfg_tdata_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

    a_done_single: assert property (@(posedge aclk) disable iff (!rst_n) done |=> !done);

    a_cfg_hold: assert property (@(posedge aclk) disable iff (!rst_n)
        bus.cfg_tvalid && !bus.cfg_tready && !core_event
        |=> bus.cfg_tvalid && $stable(bus.cfg_tdata));

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: stimulus pushes expected cfg words, input beats and
// done/frame counts; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fft_frame_ctrl;
    localparam int unsigned N = 8;

    logic        aclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        fwd = 1'b0;
    logic        clr_err = 1'b0;
    logic        ev_miss = 1'b0;
    logic        ev_unexp = 1'b0;
    logic        busy, done, err;
    logic [15:0] frame_cnt;

    fft_frame_ctrl_if bus();

    fft_frame_ctrl #(
        .LOG2_N    (3),
        .SCALE_SCH (15'h0220)
    ) dut (
        .aclk                (aclk),
        .rst_n               (rst_n),
        .start               (start),
        .fwd                 (fwd),
        .clr_err             (clr_err),
        .bus                 (bus),
        .ev_tlast_missing    (ev_miss),
        .ev_tlast_unexpected (ev_unexp),
        .busy                (busy),
        .done                (done),
        .err                 (err),
        .frame_cnt           (frame_cnt)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_frames = 0;
    logic [23:0] cfg_q[$];
    logic [32:0] in_q[$];
    logic [15:0] done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0h expected no beat", name, act);
    endtask

    // Monitor: sample away from the rising edge; a beat seen here completes on the next edge.
    always @(negedge aclk) begin
        if (rst_n) begin
            if (bus.cfg_tvalid && bus.cfg_tready) begin
                if (cfg_q.size() == 0) unexpected("cfg_beat", 64'(bus.cfg_tdata));
                else check("cfg_word", 64'(bus.cfg_tdata), 64'(cfg_q.pop_front()));
            end
            if (bus.fft_in_tvalid && bus.fft_in_tready) begin
                if (in_q.size() == 0) unexpected("in_beat", 64'({bus.fft_in_tlast, bus.fft_in_tdata}));
                else check("in_beat", 64'({bus.fft_in_tlast, bus.fft_in_tdata}), 64'(in_q.pop_front()));
            end
            if (done) begin
                if (done_q.size() == 0) unexpected("done_pulse", 64'(frame_cnt));
                else check("done_frame_cnt", 64'(frame_cnt), 64'(done_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_frame(input logic f, input bit accept);
        start = 1'b1;
        fwd   = f;
        if (accept) cfg_q.push_back({15'h0220, f, 3'b000, 5'd3});
        #1;
        check("cfg_valid_latency", 64'(bus.cfg_tvalid), 64'(0));
        tick();
        start = 1'b0;
        check("cfg_valid_after_start", 64'(bus.cfg_tvalid), 64'(accept));
        check("busy_after_start", 64'(busy), 64'(accept));
    endtask

    task automatic cfg_beat(input int stall, input logic [23:0] word);
        bus.cfg_tready = 1'b0;
        repeat (stall) begin
            tick();
            check("cfg_valid_stall", 64'(bus.cfg_tvalid), 64'(1));
            check("cfg_data_stall", 64'(bus.cfg_tdata), 64'(word));
        end
        bus.cfg_tready = 1'b1;
        tick();
        bus.cfg_tready = 1'b0;
        check("cfg_valid_drop", 64'(bus.cfg_tvalid), 64'(0));
    endtask

    // Gap pattern cycles through: none, source idle, core not ready.
    task automatic feed(input int count, input logic [31:0] base);
        for (int i = 0; i < count; i++) begin
            logic [31:0] data;
            data = base + 32'(i) * 32'h0001_0003;
            in_q.push_back({(i == N - 1), data});
            bus.src_tdata = data;
            if (i % 3 == 1) begin
                bus.src_tvalid    = 1'b0;
                bus.fft_in_tready = 1'b1;
                tick();
            end else if (i % 3 == 2) begin
                bus.src_tvalid    = 1'b1;
                bus.fft_in_tready = 1'b0;
                #1;
                check("src_ready_follows", 64'(bus.src_tready), 64'(0));
                tick();
            end
            bus.src_tvalid    = 1'b1;
            bus.fft_in_tready = 1'b1;
            tick();
        end
        bus.src_tvalid    = 1'b0;
        bus.fft_in_tready = 1'b0;
    endtask

    task automatic unload(input int tlast_beat);
        for (int i = 0; i < N; i++) begin
            bus.fft_out_tvalid = 1'b1;
            bus.fft_out_tlast  = (i == tlast_beat);
            if (i % 2 == 1) begin
                bus.snk_tready = 1'b0;
                #1;
                check("out_ready_gated", 64'(bus.fft_out_tready), 64'(0));
                tick();
            end
            bus.snk_tready = 1'b1;
            if (i == N - 1 && tlast_beat == N - 1) begin
                exp_frames++;
                done_q.push_back(16'(exp_frames));
            end
            tick();
            if (i == tlast_beat && i != N - 1) break;
        end
        bus.fft_out_tvalid = 1'b0;
        bus.fft_out_tlast  = 1'b0;
        bus.snk_tready     = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_cleared", 64'(err), 64'(0));
    endtask

    initial begin
        bus.cfg_tready     = 1'b0;
        bus.src_tdata      = '0;
        bus.src_tvalid     = 1'b1;
        bus.fft_in_tready  = 1'b1;
        bus.fft_out_tvalid = 1'b0;
        bus.fft_out_tlast  = 1'b0;
        bus.snk_tready     = 1'b1;

        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("rst_cfg_valid", 64'(bus.cfg_tvalid), 64'(0));
        check("rst_cfg_data", 64'(bus.cfg_tdata), 64'(0));
        check("rst_src_ready", 64'(bus.src_tready), 64'(0));
        check("rst_in_valid", 64'(bus.fft_in_tvalid), 64'(0));
        check("rst_out_ready", 64'(bus.fft_out_tready), 64'(0));
        bus.src_tvalid    = 1'b0;
        bus.fft_in_tready = 1'b0;
        bus.snk_tready    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Forward frame, no config stall, gapped input, clean results
        start_frame(1'b1, 1'b1);
        check("cfg_word_fwd", 64'(bus.cfg_tdata), 64'(24'h044103));
        cfg_beat(0, 24'h044103);
        feed(N, 32'hA000_0000);
        check("busy_unload", 64'(busy), 64'(1));
        unload(N - 1);
        check("busy_after_frame", 64'(busy), 64'(0));
        check("frame_cnt_1", 64'(frame_cnt), 64'(1));
        check("err_clean", 64'(err), 64'(0));

        // Inverse frame with stalled config, early core tlast
        start_frame(1'b0, 1'b1);
        cfg_beat(5, 24'h044003);
        bus.fft_in_tready = 1'b1;
        #1;
        check("load_entered", 64'(bus.src_tready), 64'(1));
        bus.fft_in_tready = 1'b0;
        feed(N, 32'hB000_0010);
        unload(4);
        check("mismatch_err", 64'(err), 64'(1));
        check("mismatch_idle", 64'(busy), 64'(0));
        check("mismatch_no_done", 64'(done), 64'(0));
        check("mismatch_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        start_frame(1'b1, 1'b0);
        pulse_clr();
        start   = 1'b1;
        clr_err = 1'b1;
        tick();
        start   = 1'b0;
        clr_err = 1'b0;
        check("start_with_clr_ignored", 64'(busy), 64'(0));

        // Core events: ignored in IDLE, abort in LOAD
        ev_miss = 1'b1;
        tick();
        ev_miss = 1'b0;
        check("event_idle_ignored", 64'(err), 64'(0));
        start_frame(1'b1, 1'b1);
        cfg_beat(0, 24'h044103);
        feed(3, 32'hC000_0020);
        bus.fft_in_tready = 1'b1;
        ev_unexp = 1'b1;
        #1;
        check("src_ready_in_load", 64'(bus.src_tready), 64'(1));
        tick();
        ev_unexp = 1'b0;
        check("event_src_ready_low", 64'(bus.src_tready), 64'(0));
        check("event_err", 64'(err), 64'(1));
        check("event_idle", 64'(busy), 64'(0));
        check("event_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        bus.fft_in_tready = 1'b0;
        pulse_clr();

        // Reset after input beat 4, then a clean frame
        start_frame(1'b0, 1'b1);
        cfg_beat(0, 24'h044003);
        feed(4, 32'hD000_0030);
        bus.src_tvalid    = 1'b1;
        bus.fft_in_tready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_frames = 0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_src_ready", 64'(bus.src_tready), 64'(0));
        check("midrst_in_valid", 64'(bus.fft_in_tvalid), 64'(0));
        check("midrst_cfg_data", 64'(bus.cfg_tdata), 64'(0));
        check("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
        bus.src_tvalid    = 1'b0;
        bus.fft_in_tready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(1'b1, 1'b1);
        cfg_beat(0, 24'h044103);
        feed(N, 32'hE000_0040);
        unload(N - 1);
        check("post_rst_frame_cnt", 64'(frame_cnt), 64'(1));
        tick();

        check("cfg_q_drained", 64'(cfg_q.size()), 64'(0));
        check("in_q_drained", 64'(in_q.size()), 64'(0));
        check("done_q_drained", 64'(done_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
